cache_way_array: RTL
====================

Name: cache_way_array

Overview:
Parametrised multi-way cache metadata/data array that holds num_sets × num_ways entries of width bits. The cache datapath and controller use it for tag, valid, dirty and LRU arrays. Each way has its own write enable. All ways at one index are read in the same cycle. A built-in flush sequencer clears the whole array one set per cycle without any help from the controller.

Parameters:
s_index, 4, index width in bits; num_sets = 2**s_index
width, 1, bits per entry
num_ways, 2, number of ways; must be ≥1

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low; 0 = reset asserted
load  input  num_ways  per-way write enable; bit w writes way w
index  input  s_index  set index shared by read and write
datain  input  num_ways*width  write data; way w occupies bits [w*width +: width]
flush  input  1  single-cycle request to start the clear sweep
dataout  output  num_ways*width  read data for all ways at index; same packing as datain
busy  output  1  high while the sweep is in progress
flush_done  output  1  one-cycle pulse after the last set is cleared

Behaviour:
- Reset (rst=0, asynchronous):
  - all entries → 0; FSM → IDLE; sweep counter → 0
  - busy=0, flush_done=0
  - dataout=0, because the array is cleared
  - Reset mid-sweep aborts the sweep immediately; no flush_done pulse is produced.
- Read:
  - combinational; dataout[w] = entry[index][w]
  - no latency; index may change every cycle
- Write (IDLE only):
  - on the rising edge, every way w with load[w]=1 stores datain[w] at index
  - ways with load[w]=0 hold their value
  - load = all-zeros is a no-op
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP: when flush=1. Any loads in that same cycle are still committed.
  - SWEEP: each cycle, all ways at set = counter are cleared to 0 and counter increments.
    - busy=1
    - load is ignored completely; no write lands
    - flush is ignored
    - dataout still reflects live array contents at index, so sets may be partially cleared
  - SWEEP → DONE: on the cycle that clears set num_sets-1. The counter wraps to 0.
  - DONE: flush_done=1 and busy=0 for one cycle. Loads are accepted in DONE. Next state is always IDLE.
- Timing: a sweep takes exactly num_sets cycles in SWEEP. flush_done pulses on cycle num_sets+1 after the flush edge.
- Timing: the sweep sequencer cycle count is fixed by num_sets; a flush re-asserted in DONE is ignored.
- s_index=1: the sweep takes 2 cycles and the counter wraps 1 → 0.
- Simultaneous events:
  - flush and load in IDLE: the write commits, then the sweep clears it.
  - load in the first SWEEP cycle: dropped.

Optional Feature:
CACHE_WAY_BYPASS_EN
- Defined: write-to-read forwarding. When the FSM is in IDLE or DONE and load[w]=1, dataout[w] = datain[w] in that same cycle. Index matches trivially because read and write share one index. Forwarding is per way; ways with load=0 show stored data.
- Not defined: dataout shows the old stored value until the edge after the write.
- Forwarding never applies while busy=1, since loads are ignored then.

Test Plan:
- Reset/read:
  - stimulus: pulse rst=0 with s_index=4, width=8, num_ways=2; then sweep index 0..15
  - response: dataout=16'h0000 at every index; busy=0; flush_done=0
- Per-way write:
  - stimulus: index=5, load=2'b01, datain=16'hBBAA; next cycle load=2'b10, datain=16'hCC11
  - response: index 5 reads 16'hCCAA; index 4 reads 16'h0000
- Bypass:
  - stimulus: index=3, load=2'b11, datain=16'h1234; sample dataout before the edge
  - response with macro: 16'h1234; without macro: 16'h0000, then 16'h1234 after the edge
- Flush sweep:
  - stimulus: fill all 16 sets with 16'hFFFF, then pulse flush
  - response: busy=1 for 16 cycles; flush_done=1 on cycle 17; all sets read 0
  - response: load=2'b11 with 16'hAAAA, presented during the sweep at index 0 after set 0 has been cleared, is dropped; index 0 reads 0
- Simultaneous flush and load:
  - stimulus: in IDLE, flush=1 with load=2'b11, index=7, datain=16'h5A5A
  - response: index 7 reads 16'h5A5A for the cycles until the sweep reaches set 7, then 0; end state IDLE
- Reset mid-sweep:
  - stimulus: assert rst=0 at sweep cycle 6
  - response: busy drops immediately; no flush_done pulse; all entries read 0; a new flush restarts from set 0

Source files
------------

// File: rtl/cache_way_array.sv
// Multi-way cache array (num_sets x num_ways entries of width bits) with a built-in flush sweep; optional CACHE_WAY_BYPASS_EN enables write-to-read forwarding.
// Latency: reads are combinational (zero cycles); writes land on the next rising edge; a flush takes num_sets SWEEP cycles plus one DONE cycle.
// Backpressure: none; while busy is high, loads and flush requests are silently dropped.
module cache_way_array #(
    parameter int s_index  = 4,
    parameter int width    = 1,
    parameter int num_ways = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [num_ways-1:0]         load,
    input  logic [s_index-1:0]          index,
    input  logic [num_ways*width-1:0]   datain,
    input  logic                        flush,
    output logic [num_ways*width-1:0]   dataout,
    output logic                        busy,
    output logic                        flush_done
);

    localparam int num_sets = 2 ** s_index;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [s_index-1:0]   cnt_q, cnt_d;
    logic [width-1:0]     mem_q [num_sets][num_ways];

    // State and sweep-counter registers; reset aborts any sweep in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter only advances in SWEEP and wraps to 0 after the last set
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush) state_d = SWEEP;
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded directly from the state register
    always_comb begin
        busy       = (state_q == SWEEP);
        flush_done = (state_q == DONE);
    end

    // Array storage: sweep clears one whole set per cycle, otherwise per-way writes at index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < num_sets; s++) begin
                for (int w = 0; w < num_ways; w++) begin
                    mem_q[s][w] <= '0;
                end
            end
        end else if (state_q == SWEEP) begin
            for (int w = 0; w < num_ways; w++) begin
                mem_q[cnt_q][w] <= '0;
            end
        end else begin
            for (int w = 0; w < num_ways; w++) begin
                if (load[w]) mem_q[index][w] <= datain[w*width +: width];
            end
        end
    end

    // Combinational read of every way at index, with optional same-cycle forwarding of loads
    always_comb begin
        dataout = '0;
        for (int w = 0; w < num_ways; w++) begin
            dataout[w*width +: width] = mem_q[index][w];
`ifdef CACHE_WAY_BYPASS_EN
            if (load[w] && (state_q != SWEEP)) begin
                dataout[w*width +: width] = datain[w*width +: width];
            end
`else
`endif
        end
    end

endmodule
